// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Round-robin arbiter that shares one combinational FP adder among NUM_REQ
//   requesters and captures each result, tagged with the requester index,
//   into a single-entry output register with its own valid/ready handshake.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cfg_rmode               rounding mode forwarded to the adder
//   req_valid / req_ready   per-requester handshake (req_ready is one-hot or 0)
//   req_data_a/b, req_mode  packed per-requester operands (slice i = [32*i+31:32*i])
//   add_*                   drive / result of the shared combinational adder
//   rsp_valid/ready/data/id result handshake, result and producing requester
//   op_count                accepted operations, wraps modulo 2^32
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_rmode,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_data_a,
  input  logic [NUM_REQ*32-1:0] req_data_b,
  input  logic [NUM_REQ-1:0]    req_mode,
  output logic [31:0]           add_data_a,
  output logic [31:0]           add_data_b,
  output logic                  add_mode,
  output logic [1:0]            add_rmode,
  output logic                  add_valid_in,
  input  logic [31:0]           add_data_out,
  input  logic                  add_valid_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [ID_W:0]   NUM_REQ_EXT = NUM_REQ[ID_W:0];
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

  state_t          state_reg;
  logic            rsp_valid_reg;
  logic [31:0]     rsp_data_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [ID_W-1:0] ptr_reg;
  logic [31:0]     op_count_reg;

  logic [31:0]     slice_a [NUM_REQ];
  logic [31:0]     slice_b [NUM_REQ];

  logic            issue;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            grant_en;
  logic [ID_W:0]   search_idx;

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice_a[gi]   = req_data_a[32*gi +: 32];
      assign slice_b[gi]   = req_data_b[32*gi +: 32];
      assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // A new operation may enter when the output register is empty, or when it
  // is being drained this very cycle (pass-through, no bubble).
  assign issue = (state_reg == EMPTY) || (rsp_ready && rsp_valid_reg);

  // Round-robin search upward from the pointer with wrap-around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (search_idx >= NUM_REQ_EXT) search_idx = search_idx - NUM_REQ_EXT;
      if (!grant_found && req_valid[search_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx[ID_W-1:0];
      end
    end
  end

  // rst_n gating keeps the handshake silent while reset is held, even though
  // the EMPTY reset state would otherwise allow an issue.
  assign grant_en     = rst_n && issue && grant_found;
  assign add_valid_in = grant_en;
  assign add_data_a   = grant_en ? slice_a[grant_idx] : 32'd0;
  assign add_data_b   = grant_en ? slice_b[grant_idx] : 32'd0;
  assign add_mode     = grant_en ? req_mode[grant_idx] : 1'b0;
  assign add_rmode    = cfg_rmode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      ptr_reg       <= '0;
      op_count_reg  <= '0;
    end else if (grant_en) begin
      // Capture regardless of add_valid_out; the adder is combinational.
      state_reg     <= FULL;
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= add_data_out;
      rsp_id_reg    <= grant_idx;
      ptr_reg       <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      op_count_reg  <= op_count_reg + 32'd1;
    end else if (issue && rsp_valid_reg) begin
      // Drained with nothing to refill: data and id keep their last values.
      state_reg     <= EMPTY;
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign op_count  = op_count_reg;

  // add_valid_out mirrors add_valid_in for a healthy adder; it carries no
  // control meaning here.
  logic unused_ok;
  assign unused_ok = add_valid_out;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter
//   Self-checking bench for fp_add_arbiter: directed vector table, hand-written
//   multi-cycle sequences (fairness, backpressure, async reset) and a random
//   phase, all compared cycle by cycle against a behavioural model.
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      cfg_rmode;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_data_a;
  logic [N*32-1:0] req_data_b;
  logic [N-1:0]    req_mode;
  logic [31:0]     add_data_a, add_data_b, add_data_out;
  logic            add_mode, add_valid_in, add_valid_out;
  logic [1:0]      add_rmode;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     op_count;

  logic [31:0] a_in [N];
  logic [31:0] b_in [N];

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  logic [31:0] m_cnt;
  int          m_last_g;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data_a[32*i +: 32] = a_in[i];
      req_data_b[32*i +: 32] = b_in[i];
    end
  end

  // Stand-in for the shared adder: the listed vectors carry real IEEE-754
  // results; everything else maps to a deterministic hash so that routing of
  // operands, mode and rmode is still observable.
  function automatic logic [31:0] fake_add(logic [31:0] a, logic [31:0] b,
                                           logic m, logic [1:0] rm);
    if (a == 32'h3F800000 && b == 32'h40000000 && !m) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 && m)  return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'h33800000 && !m)
      return (rm == 2'b10) ? 32'h3F800001 : 32'h3F800000;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, m, rm};
  endfunction

  assign add_data_out  = fake_add(add_data_a, add_data_b, add_mode, add_rmode);
  assign add_valid_out = add_valid_in;

  fp_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rmode(cfg_rmode),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data_a(req_data_a), .req_data_b(req_data_b), .req_mode(req_mode),
    .add_data_a(add_data_a), .add_data_b(add_data_b), .add_mode(add_mode),
    .add_rmode(add_rmode), .add_valid_in(add_valid_in),
    .add_data_out(add_data_out), .add_valid_out(add_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_id = 0; m_cnt = '0; m_last_g = -1;
  endtask

  // Who should be granted now, from the round-robin rule in plain arithmetic.
  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs at the falling edge, advance the
  // model at the rising edge, check registered outputs 1 time unit later.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = (g >= 0) ? N'(1) << g : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("add_valid_in", 32'(add_valid_in), 32'(g >= 0));
    chk("add_rmode", 32'(add_rmode), 32'(cfg_rmode));
    if (g >= 0) begin
      chk("add_data_a", add_data_a, a_in[g]);
      chk("add_data_b", add_data_b, b_in[g]);
      chk("add_mode", 32'(add_mode), 32'(req_mode[g]));
      chk("adder_valid_at_capture", 32'(add_valid_out), 32'd1);
    end else begin
      chk("add_idle_zero", {add_data_a | add_data_b} | 32'(add_mode), 32'd0);
    end
    @(posedge clk);
    m_last_g = g;
    if (g >= 0) begin
      m_full = 1; m_id = g; m_ptr = (g + 1) % N; m_cnt = m_cnt + 1;
      m_data = fake_add(a_in[g], b_in[g], req_mode[g], cfg_rmode);
    end else if (rst_n && m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("op_count", op_count, m_cnt);
    $display("cyc t=%0t valid=%b ready=%b grant=%0d rsp_v=%b id=%0d data=%h cnt=%0d",
             $time, req_valid, req_ready, g, rsp_valid, rsp_id, rsp_data, op_count);
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_mode = '0; rsp_ready = 1'b1; cfg_rmode = 2'b00;
    for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    clear_inputs();
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [1:0]  rmode;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [5];
  int   fair_order [6];
  logic [31:0] held_data;

  initial begin
    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000};
    vecs[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 2'b00, 32'h40000000};
    vecs[2] = '{1, 32'h3F800000, 32'h33800000, 1'b0, 2'b11, 32'h3F800000};
    vecs[3] = '{3, 32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001};
    vecs[4] = '{0, 32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000};
    fair_order = '{0, 1, 2, 3, 0, 1};

    // Reset state, with requests already asserted to show gating.
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    req_valid = '1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_add_valid_in", 32'(add_valid_in), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_op_count", op_count, 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table: single requester, rsp_ready=1.
    for (int v = 0; v < 5; v++) begin
      a_in[vecs[v].id] = vecs[v].a;
      b_in[vecs[v].id] = vecs[v].b;
      req_mode[vecs[v].id] = vecs[v].mode;
      cfg_rmode = vecs[v].rmode;
      req_valid = N'(1) << vecs[v].id;
      rsp_ready = 1'b1;
      #1;
      chk("vec_same_cycle_ready", 32'(req_ready), 32'(N'(1) << vecs[v].id));
      cycle();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("vec_rsp_data", rsp_data, vecs[v].exp_data);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("vec_op_count", op_count, 32'(v + 1));
      req_valid = '0;
      cycle();
      chk("vec_drained", 32'(rsp_valid), 32'd0);
    end

    // Fairness: all requesters held valid from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_in[i] = 32'h1000_0000 + i; b_in[i] = 32'h0000_0100 * i;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(N'(1) << fair_order[k]));
      cycle();
      chk("fair_rsp_id", 32'(rsp_id), 32'(fair_order[k]));
      chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    chk("fair_op_count", op_count, 32'd6);
    req_valid = '0;
    cycle();

    // Backpressure: move pointer to 1, then req 1 and req 3 with rsp_ready=0.
    do_reset();
    a_in[0] = 32'h0A0A_0A0A; req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    a_in[1] = 32'h1111_1111; b_in[1] = 32'h2222_2222;
    a_in[3] = 32'h3333_3333; b_in[3] = 32'h4444_4444; req_mode[3] = 1'b1;
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    cycle();
    chk("bp_first_id", 32'(rsp_id), 32'd1);
    held_data = fake_add(32'h1111_1111, 32'h2222_2222, 1'b0, 2'b00);
    chk("bp_first_data", rsp_data, held_data);
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_data", rsp_data, held_data);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b1000);
    cycle();
    chk("bp_second_id", 32'(rsp_id), 32'd3);
    chk("bp_second_data", rsp_data, fake_add(32'h3333_3333, 32'h4444_4444, 1'b1, 2'b00));
    req_valid = '0;
    cycle();

    // Async reset while FULL, mid-cycle.
    req_valid = 4'b0010; rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    chk("ar_full_before", 32'(rsp_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid_now", 32'(rsp_valid), 32'd0);
    chk("ar_op_count_now", op_count, 32'd0);
    model_reset();
    @(posedge clk); #1;
    req_valid = 4'b1000; rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1000;
    cycle();
    chk("ar_first_id", 32'(rsp_id), 32'd3);
    req_valid = '1;
    #1;
    chk("ar_ptr_wrapped", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;
    cycle();

    // Random phase: requesters hold operands until accepted.
    for (int it = 0; it < 400; it++) begin
      if (m_last_g >= 0) req_valid[m_last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          a_in[i] = $urandom; b_in[i] = $urandom;
          req_mode[i] = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (req_valid == '0) cfg_rmode = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against an accidental hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational FP_Adder instance (single-precision add/sub, 2-bit rounding mode) among NUM_REQ requesters. Each requester has a valid/ready handshake. The block drives the adder's operand, mode and valid inputs from the granted requester. It captures the adder result, tagged with the requester ID, into a single-entry output register that has its own valid/ready handshake. It sits between the convolution/MAC lanes and the shared adder and owns the rounding-mode configuration.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_rmode  input  2  rounding mode forwarded to the adder (00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero)
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_data_a  input  NUM_REQ*32  operand A; slice i is [32*i+31:32*i]
req_data_b  input  NUM_REQ*32  operand B, same packing
req_mode  input  NUM_REQ  0 = add, 1 = subtract (A-B)
add_data_a  output  32  to FP_Adder Data_A
add_data_b  output  32  to FP_Adder Data_B
add_mode  output  1  to FP_Adder Mode
add_rmode  output  2  to FP_Adder RMode; equals cfg_rmode
add_valid_in  output  1  to FP_Adder Valid_In
add_data_out  input  32  from FP_Adder Data_Out
add_valid_out  input  1  from FP_Adder Valid_Out
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accept
rsp_data  output  32  result
rsp_id  output  ID_W  index of the requester that produced rsp_data
op_count  output  32  number of accepted operations; wraps modulo 2^32

Behaviour:
- Reset (async, rst_n=0):
  - FSM state = EMPTY.
  - rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0.
  - RR pointer = 0.
  - req_ready=0 and add_valid_in=0 while reset is asserted.
- FSM, 2 states:
  - EMPTY: output register holds nothing.
  - FULL: output register holds an unconsumed result.
- Issue condition: issue = (state==EMPTY) | (rsp_ready & rsp_valid).
  - In FULL with rsp_ready=1, the drain and the refill happen in the same cycle (pass-through). No bubble.
- Arbitration (combinational):
  - Among the asserted req_valid bits, grant the first index found searching upward from the pointer, with wrap-around.
  - A grant is produced only when issue=1; otherwise req_ready is all zeros.
- Adder drive:
  - add_data_a, add_data_b and add_mode come from the granted slice.
  - add_valid_in = issue & |req_valid.
  - When nothing is granted, the operand outputs are 0 and add_mode is 0.
- Capture (at the clock edge of an accepted handshake, i.e. req_valid[g] & req_ready[g]):
  - rsp_data <= add_data_out; rsp_id <= g; rsp_valid <= 1.
  - Pointer <= (g+1) mod NUM_REQ.
  - op_count <= op_count+1.
  - Result latency: 1 cycle from acceptance to rsp_valid.
- Drain without refill (FULL & rsp_ready & no request): rsp_valid <= 0, state -> EMPTY. rsp_data and rsp_id hold their last values.
- FULL & !rsp_ready: hold everything. rsp_data, rsp_id and rsp_valid are stable, and no requester is granted.
- The pointer advances only on an accepted grant. A requester holding req_valid is served within NUM_REQ grants (no starvation).
- Requester rules: a requester must hold its operands and mode stable while req_valid=1 and req_ready=0. It may drop req_valid before being accepted without error.
- add_valid_out is a sanity input only. If add_valid_out=0 at a capture edge, the block still captures; this case is flagged by bench assertion, not in RTL.
- cfg_rmode is sampled combinationally by the adder. It is legal to change it only while no requests are pending; a change takes effect on the next issued operation.
- Reset mid-operation: a pending result is discarded, rsp_valid drops asynchronously and the pointer returns to 0.

Test Plan:
1. Single requester: req 0 sends A=0x3F800000, B=0x40000000, mode=0, rsp_ready=1 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_data=0x40400000, rsp_id=0, op_count=1.
2. Subtract: req 2 sends A=0x40400000, B=0x3F800000, mode=1 -> rsp_data=0x40000000, rsp_id=2.
3. Fairness: all 4 requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one result per cycle; op_count=6 after 6 cycles.
4. Backpressure: rsp_ready=0 with results from req 1 and req 3 pending -> rsp_data and rsp_id=1 held stable; req_ready=0 throughout; raise rsp_ready -> in the same cycle req 3 is accepted and its result appears next cycle.
5. Rounding: cfg_rmode=11, A=0x3F800000, B=0x33800000 (2^-24) -> rsp_data=0x3F800000; with cfg_rmode=10 -> 0x3F800001.
6. Async reset asserted while FULL, mid-cycle -> rsp_valid=0 immediately and op_count=0; after release, req 3 alone is granted first, and the pointer then moves to 0.
